fetch_branch_predictor: RTL and testbench
=========================================

FETCH_BRANCH_PREDICTOR -- requirements
Module: fetch_branch_predictor

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter BTB_ENTRIES, default 64, number of direct-mapped entries (power of two, 4..1024); IDXW = log2(BTB_ENTRIES).
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-low.
REQ-005 i_stall_fetch  input  1  hold PC (load-use / structural stall).
REQ-006 i_ex_branch  input  1  a branch/jump is resolved in EX this cycle.
REQ-007 i_ex_pc  input  32  PC of the resolving instruction.
REQ-008 i_ex_taken  input  1  actual outcome.
REQ-009 i_ex_target  input  32  actual taken target.
REQ-010 i_ex_pred_taken  input  1  prediction carried down the pipe with that instruction.
REQ-011 i_ex_pred_target  input  32  predicted target carried with that instruction.
REQ-012 o_pc  output  32  fetch PC, drives instruction memory address.
REQ-013 o_pred_taken  output  1  prediction for current o_pc (combinational).
REQ-014 o_pred_target  output  32  predicted target for current o_pc (combinational).
REQ-015 o_mispredict  output  1  redirect this cycle (combinational).
REQ-016 o_flush_decode, o_flush_execute  output  1 each  flush requests, equal to o_mispredict.

Function
REQ-017 Table entry: valid (1), tag = pc[31:IDXW+2], target (32, bits [1:0] stored as 00), history bit (1); index = pc[IDXW+1:2].
REQ-018 Lookup on o_pc: hit = valid && tag match; o_pred_taken = hit && history; o_pred_target = hit ? target : o_pc+4.
REQ-019 Mispredict = i_ex_branch && ((i_ex_taken != i_ex_pred_taken) || (i_ex_taken && i_ex_target != i_ex_pred_target)).
REQ-020 Next-PC priority: mispredict > stall > prediction; mispredict overrides i_stall_fetch.
REQ-021 On mispredict, next o_pc = i_ex_taken ? {i_ex_target[31:2],2'b00} : i_ex_pc+4.
REQ-022 Else if i_stall_fetch, o_pc holds.
REQ-023 Else next o_pc = o_pred_taken ? o_pred_target : o_pc+4.
REQ-024 PC+4 arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-025 o_pc[1:0] SHALL always be 2'b00.
REQ-026 Update (every i_ex_branch, regardless of stall): if taken, write entry at i_ex_pc index: valid=1, tag, target, history=1 (allocate or overwrite).
REQ-027 If not taken and entry hits, clear history only; if not taken and miss, no write.
REQ-028 Update and lookup of the same index in one cycle: lookup uses pre-update contents; new contents visible from next cycle.
REQ-029 Redirect latency: o_pc equals corrected PC on the edge following o_mispredict; flush outputs asserted in the mispredict cycle only.
REQ-030 No multi-cycle state: each cycle independent except PC register and table.

Reset
REQ-031 While i_reset low: o_pc = RESET_PC, all valid and history bits 0; targets/tags need not reset.
REQ-032 After reset release, o_pred_taken = 0 and o_mispredict = 0 until first i_ex_branch.
REQ-033 Reset asserted mid-redirect SHALL discard the redirect; o_pc = RESET_PC on release.

Verification
REQ-034 Reset, no branches, 4 clocks -> o_pc 0x0,0x4,0x8,0xC; o_pred_taken 0.
REQ-035 EX: pc=0x10, taken, target=0x40, pred_taken=0 -> o_mispredict=1, flushes=1, next o_pc=0x40; later fetch of 0x10 -> o_pred_taken=1, o_pred_target=0x40, next o_pc=0x40.
REQ-036 Entry 0x10 trained; EX: pc=0x10, not taken, pred_taken=1 -> next o_pc=0x14, history cleared; next fetch 0x10 -> o_pred_taken=0.
REQ-037 i_stall_fetch=1 with mispredict (pc=0x20 taken to 0x100) -> o_pc=0x100 next edge; stall without mispredict -> o_pc holds 3 cycles.
REQ-038 Aliasing: train 0x10 (taken 0x40), fetch 0x110 (same index, BTB_ENTRIES=64) -> o_pred_taken=0 (tag miss).
REQ-039 o_pc=0xFFFF_FFFC, no prediction -> next o_pc=0x0000_0000; assert i_reset mid-sequence -> o_pc=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_branch_predictor.sv
// Fetch PC register with a direct-mapped BTB and one-bit taken history.
// Redirects on EX-resolved mispredictions and trains the table every resolved branch.
module fetch_branch_predictor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall_fetch,
  input  logic        i_ex_branch,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic [31:0] o_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic        o_mispredict,
  output logic        o_flush_decode,
  output logic        o_flush_execute
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDXW;

  // PC and targets are kept as word addresses; the low two bits are always zero.
  logic [29:0]            pc_q;
  logic [29:0]            pc_next;
  logic [29:0]            pc_plus4;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_ENTRIES-1:0] hist_q;
  logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
  logic [29:0]            tgt_q [BTB_ENTRIES];

  logic [IDXW-1:0] fetch_idx;
  logic [TAGW-1:0] fetch_tag;
  logic            fetch_hit;
  logic [IDXW-1:0] ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;
  logic [29:0]     ex_pc_plus4;
  logic            mispredict;
  logic [3:0]      unused_bits;

  assign unused_bits = {i_ex_pc[1:0], i_ex_target[1:0]};

  assign fetch_idx = pc_q[IDXW-1:0];
  assign fetch_tag = pc_q[29:IDXW];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pc_plus4  = pc_q + 30'd1;

  assign o_pc          = {pc_q, 2'b00};
  assign o_pred_taken  = fetch_hit && hist_q[fetch_idx];
  assign o_pred_target = fetch_hit ? {tgt_q[fetch_idx], 2'b00} : {pc_plus4, 2'b00};

  assign ex_idx      = i_ex_pc[IDXW+1:2];
  assign ex_tag      = i_ex_pc[31:IDXW+2];
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_pc_plus4 = i_ex_pc[31:2] + 30'd1;

  assign mispredict = i_ex_branch &&
                      ((i_ex_taken != i_ex_pred_taken) ||
                       (i_ex_taken && (i_ex_target != i_ex_pred_target)));

  assign o_mispredict    = mispredict;
  assign o_flush_decode  = mispredict;
  assign o_flush_execute = mispredict;

  // Redirect beats stall, stall beats prediction.
  always_comb begin
    pc_next = pc_plus4;
    if (mispredict) begin
      pc_next = i_ex_taken ? i_ex_target[31:2] : ex_pc_plus4;
    end else if (i_stall_fetch) begin
      pc_next = pc_q;
    end else if (o_pred_taken) begin
      pc_next = o_pred_target[31:2];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q <= RESET_PC[31:2];
    end else begin
      pc_q <= pc_next;
    end
  end

  // Training ignores stall: a branch resolving in EX always updates the table.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= '0;
      hist_q  <= '0;
    end else if (i_ex_branch) begin
      if (i_ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        hist_q[ex_idx]  <= 1'b1;
      end else if (ex_hit) begin
        hist_q[ex_idx]  <= 1'b0;
      end
    end
  end

  // Tags and targets are qualified by valid_q, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (i_ex_branch && i_ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= i_ex_target[31:2];
    end
  end

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Directed vector bench for fetch_branch_predictor with BTB_ENTRIES=64, RESET_PC=0.
module tb_fetch_branch_predictor;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall_fetch;
  logic        i_ex_branch;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic [31:0] o_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        o_mispredict;
  logic        o_flush_decode;
  logic        o_flush_execute;

  int checks = 0;
  int failures = 0;

  fetch_branch_predictor #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(64)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall_fetch(i_stall_fetch),
    .i_ex_branch(i_ex_branch), .i_ex_pc(i_ex_pc), .i_ex_taken(i_ex_taken),
    .i_ex_target(i_ex_target), .i_ex_pred_taken(i_ex_pred_taken),
    .i_ex_pred_target(i_ex_pred_target), .o_pc(o_pc), .o_pred_taken(o_pred_taken),
    .o_pred_target(o_pred_target), .o_mispredict(o_mispredict),
    .o_flush_decode(o_flush_decode), .o_flush_execute(o_flush_execute)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] ex_pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_misp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic stall, input logic br, input logic [31:0] ex_pc,
                     input logic tk, input logic [31:0] tgt, input logic ptk,
                     input logic [31:0] ptgt, input logic [31:0] e_pc, input logic e_pt,
                     input logic [31:0] e_ptgt, input logic e_misp);
    vec_t v;
    v.stall = stall; v.br = br; v.ex_pc = ex_pc; v.tk = tk; v.tgt = tgt;
    v.ptk = ptk; v.ptgt = ptgt; v.e_pc = e_pc; v.e_pt = e_pt;
    v.e_ptgt = e_ptgt; v.e_misp = e_misp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_stall_fetch = 0; i_ex_branch = 0; i_ex_pc = 0; i_ex_taken = 0;
    i_ex_target = 0; i_ex_pred_taken = 0; i_ex_pred_target = 0;
  endtask

  task automatic apply(input vec_t v, input int n);
    string tag;
    i_stall_fetch = v.stall; i_ex_branch = v.br; i_ex_pc = v.ex_pc;
    i_ex_taken = v.tk; i_ex_target = v.tgt; i_ex_pred_taken = v.ptk;
    i_ex_pred_target = v.ptgt;
    #1;
    tag = $sformatf("v%0d", n);
    check({tag, "_pc"}, o_pc, v.e_pc);
    check({tag, "_pred_taken"}, {31'd0, o_pred_taken}, {31'd0, v.e_pt});
    check({tag, "_pred_target"}, o_pred_target, v.e_ptgt);
    check({tag, "_mispredict"}, {31'd0, o_mispredict}, {31'd0, v.e_misp});
    check({tag, "_flushes"}, {30'd0, o_flush_decode, o_flush_execute}, {30'd0, v.e_misp, v.e_misp});
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    // stall br ex_pc tk tgt ptk ptgt | exp pc pt ptgt misp
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h0,   0,32'h4,   0);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h4,   0,32'h8,   0);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h8,   0,32'hC,   0);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'hC,   0,32'h10,  0);
    add(0,1,32'h10, 1,32'h40, 0,32'h14,  32'h10,  0,32'h14,  1);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h40,  0,32'h44,  0);
    add(0,1,32'hC,  0,32'h0,  0,32'h0,   32'h44,  0,32'h48,  0);
    add(0,1,32'hC,  1,32'h10, 0,32'h10,  32'h48,  0,32'h4C,  1);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h10,  1,32'h40,  0);
    add(0,1,32'h10, 0,32'h0,  1,32'h40,  32'h40,  0,32'h44,  1);
    add(0,1,32'hC,  1,32'h10, 0,32'h10,  32'h14,  0,32'h18,  1);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h10,  0,32'h40,  0);
    add(1,1,32'h20, 1,32'h100,0,32'h24,  32'h14,  0,32'h18,  1);
    add(1,0,32'h0,  0,32'h0,  0,32'h0,   32'h100, 0,32'h104, 0);
    add(1,0,32'h0,  0,32'h0,  0,32'h0,   32'h100, 0,32'h104, 0);
    add(1,0,32'h0,  0,32'h0,  0,32'h0,   32'h100, 0,32'h104, 0);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h100, 0,32'h104, 0);
    add(0,1,32'h10, 1,32'h40, 1,32'h40,  32'h104, 0,32'h108, 0);
    add(0,1,32'h200,1,32'h110,0,32'h204, 32'h108, 0,32'h10C, 1);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h110, 0,32'h114, 0);
    add(0,1,32'h114,1,32'h200,0,32'h118, 32'h114, 0,32'h118, 1);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h200, 1,32'h110, 0);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h110, 0,32'h114, 0);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h114, 1,32'h200, 0);
    add(0,1,32'h300,1,32'hFFFF_FFFF,0,32'h304, 32'h200, 1,32'h110, 1);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'hFFFF_FFFC, 0,32'h0, 0);
    add(0,0,32'h0,  0,32'h0,  0,32'h0,   32'h0,   0,32'h4,   0);

    idle_inputs();
    i_reset = 1'b0;
    #1;
    check("reset_pc_async", o_pc, 32'h0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_pc_held", o_pc, 32'h0);
    check("reset_pred_taken", {31'd0, o_pred_taken}, 32'd0);
    i_reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset arriving during a redirect discards it and clears the table.
    check("pre_reset_pc", o_pc, 32'h4);
    i_ex_branch = 1; i_ex_pc = 32'h50; i_ex_taken = 1; i_ex_target = 32'h80;
    i_ex_pred_taken = 0; i_ex_pred_target = 32'h54;
    #1;
    check("mid_redirect_misp", {31'd0, o_mispredict}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("mid_redirect_reset_pc", o_pc, 32'h0);
    @(posedge i_clk);
    #1;
    check("reset_over_redirect_pc", o_pc, 32'h0);
    idle_inputs();
    @(negedge i_clk);
    i_reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("post_reset_pc%0d", k), o_pc, 32'(k * 4));
      check($sformatf("post_reset_pt%0d", k), {31'd0, o_pred_taken}, 32'd0);
      check($sformatf("post_reset_misp%0d", k), {31'd0, o_mispredict}, 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
